// File: rtl/stack_issue_if.sv
// Issue-stage <-> stack controller bundle.
// master: issue side (drives requests, push data, clr_fault; observes strobes/flags).
// slave : stack_issue_ctrl (consumes requests, drives strobes, wdata, stall, count, flags).
interface stack_issue_if #(
  parameter int unsigned CW = 11
);
  logic          req_push0;
  logic          req_pop0;
  logic          req_push1;
  logic          req_pop1;
  logic [31:0]   din0;
  logic [31:0]   din1;
  logic          clr_fault;
  logic          push0;
  logic          pop0;
  logic          push1;
  logic          pop1;
  logic [31:0]   wdata0;
  logic [31:0]   wdata1;
  logic          stall;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          fault;
  logic [1:0]    fault_code;

  modport master (
    output req_push0, req_pop0, req_push1, req_pop1, din0, din1, clr_fault,
    input  push0, pop0, push1, pop1, wdata0, wdata1, stall, count, full, empty,
           fault, fault_code
  );

  modport slave (
    input  req_push0, req_pop0, req_push1, req_pop1, din0, din1, clr_fault,
    output push0, pop0, push1, pop1, wdata0, wdata1, stall, count, full, empty,
           fault, fault_code
  );
endinterface

// File: rtl/stack_issue_ctrl.sv
// Issue-stage controller for the dual-port hardware stack.
// Ports: clk, rst_n (async active-low), bus (stack_issue_if.slave):
//   req_push0/1, req_pop0/1, din0/1, clr_fault in;
//   push0/1, pop0/1, wdata0/1, stall (Mealy), count, full, empty,
//   fault, fault_code out.
// A legal pop0 paired with push1 is split: pop0 now (with stall), push1 next cycle.
module stack_issue_ctrl #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned CW    = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  stack_issue_if.slave  bus
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [1:0]    FC_UNF  = 2'b01;
  localparam logic [1:0]    FC_OVF  = 2'b10;
  localparam logic [1:0]    FC_ILL  = 2'b11;

  typedef enum logic [0:0] {IDLE = 1'b0, SPLIT = 1'b1} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;
  logic [CW-1:0] w_eff;
  logic          r_fault;
  logic [1:0]    r_fault_code;
  logic [31:0]   r_cap_data;

  logic          w_ill0, w_ill1;
  logic          w_p0, w_q0, w_p1, w_q1;
  logic          w_push0, w_pop0, w_push1, w_pop1;
  logic [31:0]   w_wdata0, w_wdata1;
  logic          w_stall, w_go_split;
  logic          w_err_ill, w_err_unf, w_err_ovf, w_err_any;
  logic [1:0]    w_err_code;

  // Per-slot request qualification: push+pop together cancels the slot.
  assign w_ill0 = bus.req_push0 & bus.req_pop0;
  assign w_ill1 = bus.req_push1 & bus.req_pop1;
  assign w_p0   = bus.req_push0 & ~w_ill0;
  assign w_q0   = bus.req_pop0  & ~w_ill0;
  assign w_p1   = bus.req_push1 & ~w_ill1;
  assign w_q1   = bus.req_pop1  & ~w_ill1;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_go_split) w_state_nxt = SPLIT;
      SPLIT:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output/decode logic: slot 0 resolved first, slot 1 against w_eff.
  always_comb begin
    w_push0    = 1'b0;
    w_pop0     = 1'b0;
    w_push1    = 1'b0;
    w_pop1     = 1'b0;
    w_wdata0   = bus.din0;
    w_wdata1   = bus.din1;
    w_stall    = 1'b0;
    w_go_split = 1'b0;
    w_err_ill  = 1'b0;
    w_err_unf  = 1'b0;
    w_err_ovf  = 1'b0;
    w_eff      = r_count;
    case (r_state)
      SPLIT: begin
        w_push1  = 1'b1;
        w_wdata1 = r_cap_data;
      end
      default: begin
        w_err_ill = w_ill0 | w_ill1;
        if (w_p0 && w_q1) begin
          // Bypass pair: net zero occupancy change, never faults.
          w_push0 = 1'b1;
          w_pop1  = 1'b1;
        end else begin
          if (w_q0) begin
            if (r_count == '0) w_err_unf = 1'b1;
            else begin
              w_pop0 = 1'b1;
              w_eff  = r_count - CW'(1);
            end
          end else if (w_p0) begin
            if (r_count == DEPTH_C) w_err_ovf = 1'b1;
            else begin
              w_push0 = 1'b1;
              w_eff   = r_count + CW'(1);
            end
          end
          if (w_q1) begin
            if (w_eff == '0) w_err_unf = 1'b1;
            else             w_pop1    = 1'b1;
          end else if (w_p1) begin
            if (w_pop0) begin
              w_go_split = 1'b1;
              w_stall    = 1'b1;
            end else if (w_eff == DEPTH_C) begin
              w_err_ovf = 1'b1;
            end else begin
              w_push1 = 1'b1;
            end
          end
        end
      end
    endcase
    if (!rst_n) begin
      w_push0    = 1'b0;
      w_pop0     = 1'b0;
      w_push1    = 1'b0;
      w_pop1     = 1'b0;
      w_wdata0   = '0;
      w_wdata1   = '0;
      w_stall    = 1'b0;
      w_go_split = 1'b0;
      w_err_ill  = 1'b0;
      w_err_unf  = 1'b0;
      w_err_ovf  = 1'b0;
    end
  end

  assign w_err_any  = w_err_ill | w_err_unf | w_err_ovf;
  assign w_err_code = w_err_ill ? FC_ILL : (w_err_unf ? FC_UNF : FC_OVF);
  assign w_count_nxt = r_count + CW'(w_push0) + CW'(w_push1)
                               - CW'(w_pop0)  - CW'(w_pop1);

  // Occupancy, sticky fault (first error wins, error beats clear), split capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count      <= '0;
      r_fault      <= 1'b0;
      r_fault_code <= 2'b00;
      r_cap_data   <= '0;
    end else begin
      r_count <= w_count_nxt;
      if (w_err_any && (!r_fault || bus.clr_fault)) begin
        r_fault      <= 1'b1;
        r_fault_code <= w_err_code;
      end else if (bus.clr_fault) begin
        r_fault      <= 1'b0;
        r_fault_code <= 2'b00;
      end
      if (w_go_split) r_cap_data <= bus.din1;
    end
  end

  assign bus.push0      = w_push0;
  assign bus.pop0       = w_pop0;
  assign bus.push1      = w_push1;
  assign bus.pop1       = w_pop1;
  assign bus.wdata0     = w_wdata0;
  assign bus.wdata1     = w_wdata1;
  assign bus.stall      = w_stall;
  assign bus.count      = r_count;
  assign bus.full       = (r_count == DEPTH_C);
  assign bus.empty      = (r_count == '0);
  assign bus.fault      = r_fault;
  assign bus.fault_code = r_fault_code;

endmodule

// File: tb/tb_stack_issue_ctrl.sv
// Directed bench for stack_issue_ctrl: inputs change 1ns after posedge,
// Mealy and registered outputs are sampled at the following negedge.
module tb_stack_issue_ctrl;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned CW    = 11;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  stack_issue_if #(.CW(CW)) bus ();

  stack_issue_ctrl #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Apply one cycle of requests and stop at the negedge for sampling.
  task automatic drive(input logic p0, input logic q0, input logic p1, input logic q1,
                       input logic [31:0] d0, input logic [31:0] d1, input logic clr);
    @(posedge clk);
    #1;
    bus.req_push0 = p0;
    bus.req_pop0  = q0;
    bus.req_push1 = p1;
    bus.req_pop1  = q1;
    bus.din0      = d0;
    bus.din1      = d1;
    bus.clr_fault = clr;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    bus.req_push0 = 1'b0; bus.req_pop0 = 1'b0;
    bus.req_push1 = 1'b0; bus.req_pop1 = 1'b0;
    bus.din0 = '0; bus.din1 = '0; bus.clr_fault = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.req_push0 = 1'b1; bus.req_pop0 = 1'b0;
    bus.req_push1 = 1'b0; bus.req_pop1 = 1'b0;
    bus.din0 = 32'hDEAD; bus.din1 = 32'h0; bus.clr_fault = 1'b0;
    repeat (2) @(negedge clk);
    // Reset state, strobes forced low despite an active request.
    chk("rst_push0", 32'(bus.push0), 32'h0);
    chk("rst_wdata0", bus.wdata0, 32'h0);
    chk("rst_count", 32'(bus.count), 32'h0);
    chk("rst_empty", 32'(bus.empty), 32'h1);
    chk("rst_fault", 32'(bus.fault), 32'h0);
    chk("rst_code", 32'(bus.fault_code), 32'h0);
    bus.req_push0 = 1'b0;
    rst_n = 1'b1;

    // Three single pushes on slot 0.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'hA, 32'h0, 1'b0);
    chk("push_a", 32'(bus.push0), 32'h1);
    chk("wdata_a", bus.wdata0, 32'hA);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'hB, 32'h0, 1'b0);
    chk("wdata_b", bus.wdata0, 32'hB);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'hC, 32'h0, 1'b0);
    chk("wdata_c", bus.wdata0, 32'hC);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("count3", 32'(bus.count), 32'd3);
    chk("fault3", 32'(bus.fault), 32'h0);
    chk("pop_single", 32'(bus.pop0), 32'h1);

    // count 2: dual pop, then underflow.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
    chk("dpop_pop0", 32'(bus.pop0), 32'h1);
    chk("dpop_pop1", 32'(bus.pop1), 32'h1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("dpop_count", 32'(bus.count), 32'd0);
    chk("unf_pop0", 32'(bus.pop0), 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    chk("unf_fault", 32'(bus.fault), 32'h1);
    chk("unf_code", 32'(bus.fault_code), 32'h1);
    idle();
    chk("clr_fault", 32'(bus.fault), 32'h0);
    chk("clr_code", 32'(bus.fault_code), 32'h0);

    // Fill to DEPTH-1.
    for (int i = 0; i < 511; i++) drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h1, 32'h2, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h3, 32'h0, 1'b0);
    idle();
    chk("count1023", 32'(bus.count), 32'd1023);
    chk("full1023", 32'(bus.full), 32'h0);

    // Dual push at DEPTH-1: only push0.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h11, 32'h22, 1'b0);
    chk("ovf_push0", 32'(bus.push0), 32'h1);
    chk("ovf_push1", 32'(bus.push1), 32'h0);
    chk("ovf_wdata0", bus.wdata0, 32'h11);
    // Bypass at full: both strobes, no new fault.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h33, 32'h0, 1'b0);
    chk("full_count", 32'(bus.count), 32'd1024);
    chk("full_flag", 32'(bus.full), 32'h1);
    chk("ovf_code", 32'(bus.fault_code), 32'h2);
    chk("byp_full_push0", 32'(bus.push0), 32'h1);
    chk("byp_full_pop1", 32'(bus.pop1), 32'h1);
    // Illegal slot 1 while overflow is latched: first code stays.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 1'b0);
    idle();
    chk("byp_full_count", 32'(bus.count), 32'd1024);
    chk("first_wins", 32'(bus.fault_code), 32'h2);

    // count 5, split pop0+push1.
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h1, 32'h2, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h3, 32'h4, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h5, 32'h0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h55, 1'b0);
    chk("rst_clears_fault", 32'(bus.fault), 32'h0);
    chk("split1_pop0", 32'(bus.pop0), 32'h1);
    chk("split1_push1", 32'(bus.push1), 32'h0);
    chk("split1_stall", 32'(bus.stall), 32'h1);
    // SPLIT cycle ignores requests.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h99, 1'b0);
    chk("split2_count", 32'(bus.count), 32'd4);
    chk("split2_push1", 32'(bus.push1), 32'h1);
    chk("split2_wdata1", bus.wdata1, 32'h55);
    chk("split2_stall", 32'(bus.stall), 32'h0);
    chk("split2_pop0", 32'(bus.pop0), 32'h0);
    chk("split2_pop1", 32'(bus.pop1), 32'h0);
    idle();
    chk("split_count5", 32'(bus.count), 32'd5);
    chk("split_nofault", 32'(bus.fault), 32'h0);

    // count 0: bypass, then illegal slot 1.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h7, 32'h0, 1'b0);
    chk("byp0_push0", 32'(bus.push0), 32'h1);
    chk("byp0_pop1", 32'(bus.pop1), 32'h1);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 1'b0);
    chk("byp0_count", 32'(bus.count), 32'd0);
    chk("byp0_fault", 32'(bus.fault), 32'h0);
    chk("ill_push1", 32'(bus.push1), 32'h0);
    chk("ill_pop1", 32'(bus.pop1), 32'h0);
    // clr_fault with pop0 underflow + push1: error wins, push1 still issues.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h66, 1'b1);
    chk("ill_code", 32'(bus.fault_code), 32'h3);
    chk("unfsplit_push1", 32'(bus.push1), 32'h1);
    chk("unfsplit_pop0", 32'(bus.pop0), 32'h0);
    chk("unfsplit_stall", 32'(bus.stall), 32'h0);
    idle();
    chk("unfsplit_count", 32'(bus.count), 32'd1);
    chk("clr_err_fault", 32'(bus.fault), 32'h1);
    chk("clr_err_code", 32'(bus.fault_code), 32'h1);

    // Reset in the SPLIT cycle discards the captured push.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h77, 1'b0);
    chk("rsplit_stall", 32'(bus.stall), 32'h1);
    @(posedge clk);
    #1;
    chk("rsplit_push1_pre", 32'(bus.push1), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rsplit_push1", 32'(bus.push1), 32'h0);
    chk("rsplit_pop0", 32'(bus.pop0), 32'h0);
    chk("rsplit_stall0", 32'(bus.stall), 32'h0);
    chk("rsplit_count", 32'(bus.count), 32'd0);
    bus.req_pop0 = 1'b0; bus.req_push1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    chk("rsplit_after_push1", 32'(bus.push1), 32'h0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    chk("rsplit_count0", 32'(bus.count), 32'd0);
    chk("late_unf_fault", 32'(bus.fault), 32'h1);
    idle();
    chk("final_clr_fault", 32'(bus.fault), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stack_issue_ctrl.md
Name: stack_issue_ctrl

Overview:
- Issue-stage controller in front of the dual-port 32x1024 hardware stack used by PUSH/POP in the in-order superscalar CPU.
- Receives push/pop requests from issue slots 0 and 1 and tracks stack occupancy.
- Drives the stack's push0/push1/pop0/pop1 strobes and write data, and raises flags for overflow, underflow and illegal requests.
- Serializes pop0+push1 pairs over two cycles and stalls the pipeline for the extra cycle, because the stack cannot service that pair in one cycle.

Parameters:
- DEPTH, 1024, number of stack entries.
- CW, 11, occupancy counter width; must satisfy 2^CW > DEPTH.

Ports:
- clk  in  1  system clock, posedge.
- rst_n  in  1  asynchronous active-low reset.
- req_push0  in  1  slot 0 requests PUSH.
- req_pop0  in  1  slot 0 requests POP.
- req_push1  in  1  slot 1 requests PUSH.
- req_pop1  in  1  slot 1 requests POP.
- din0  in  32  slot 0 push data.
- din1  in  32  slot 1 push data.
- clr_fault  in  1  clears the sticky fault state.
- push0  out  1  stack push strobe, port 0.
- pop0  out  1  stack pop strobe, port 0.
- push1  out  1  stack push strobe, port 1.
- pop1  out  1  stack pop strobe, port 1.
- wdata0  out  32  stack write data, port 0.
- wdata1  out  32  stack write data, port 1.
- stall  out  1  hold both issue slots for one cycle.
- count  out  CW  current occupancy.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- fault  out  1  sticky error flag.
- fault_code  out  2  01 underflow, 10 overflow, 11 illegal; first error wins.

Behaviour:
- Reset: state IDLE, count 0, fault 0, fault_code 00, captured op cleared. While rst_n is low, all strobes, wdata and stall are forced to 0.
- Strobes, wdata and stall are combinational from state, count and current requests (Mealy). count, state and fault update on posedge clk.
- Per slot, push and pop requested together is illegal: drop both for that slot and raise code 11.
- IDLE decode, evaluated slot 0 first, then slot 1 against count after slot 0's effect:
  - Pop at effective count 0: drop the pop, code 01.
  - Push at effective count DEPTH: drop the push, code 10.
  - push0+push1 at DEPTH-1: issue push0 only, drop push1, code 10.
  - pop0+pop1 at count 1: issue pop0 only, drop pop1, code 01.
  - push0+pop1: issue both in the same cycle (stack bypass); count unchanged; legal even at count 0 or DEPTH.
  - pop0+push1 with pop0 legal: issue pop0 only, assert stall, capture push1 and din1, go to SPLIT.
  - pop0+push1 with pop0 underflowing: drop pop0, code 01, issue push1 the same cycle, no stall.
  - All other legal combinations issue unchanged. wdata0 = din0, wdata1 = din1.
- SPLIT, always one cycle:
  - Ignore the request inputs.
  - Issue the captured push1 with the captured data on wdata1. It cannot overflow because of the preceding pop.
  - stall = 0; return to IDLE.
- count next = count + pushes issued - pops issued (range -2..+2), saturating is never needed.
- Fault:
  - Set on the first error; fault_code holds the first code until cleared.
  - With several errors in one cycle, priority is illegal > underflow > overflow.
  - clr_fault clears both in the next cycle. An error in the same cycle as clr_fault wins, and its code is loaded.
  - Faults never block later requests.
- Async reset during SPLIT discards the captured push; the stack pointer is reset in parallel.

Test Plan:
- Reset, then 3 cycles of push0 only with din0 = 0xA, 0xB, 0xC -> push0 pulses 3x, count 3, no fault.
- count 2, pop0+pop1 -> both strobes in one cycle, count 0. Next cycle pop0 -> no strobe, fault = 1, code 01.
- count 1023, push0+push1 with din 0x11/0x22 -> only push0 with wdata0 = 0x11, count 1024, full = 1, code 10.
- count 5, pop0+push1 with din1 = 0x55 -> cycle 1: pop0 = 1, stall = 1, count 4. Cycle 2: push1 = 1, wdata1 = 0x55, stall = 0, count 5.
- count 0, push0+pop1 -> both strobes, count stays 0, no fault. Then req_push1+req_pop1 -> no strobes, code 11.
- Enter SPLIT, drop rst_n mid-cycle -> strobes 0 immediately, count 0, no push1 after release. Then clr_fault with no error -> fault = 0.
